m_mem_ctrl: RTL and testbench
=============================

# m_mem_ctrl

Memory-stage load/store initiator: accepts one access per instruction from the M pipeline stage and drives a word-organised data memory over a req/ack bus. It generates byte enables and replicated store data for byte/half/word stores, and extracts and sign/zero-extends load data from the returned word. It stalls the pipeline while the access is outstanding and aborts on timeout.

## Interface
- TIMEOUT, 255: max cycles waiting for m_ack before abort (1..255)
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- req_valid  input  1  M stage holds a load/store
- req_we  input  1  1 = store, 0 = load
- req_width  input  2  2'b00 WORD, 2'b01 HALF, 2'b10 BYTE (2'b11 treated as WORD)
- req_sign  input  1  load extension: 1 sign, 0 zero
- req_addr  input  32  byte address
- req_wdata  input  32  store data, LSB-justified
- stall  output  1  freeze pipeline (combinational)
- rdata  output  32  extended load result
- rdata_valid  output  1  one-cycle pulse, rdata usable
- bus_err  output  1  one-cycle pulse, timeout abort
- m_req  output  1  bus request, held until ack
- m_we  output  1  bus write
- m_addr  output  32  {req_addr[31:2],2'b00}
- m_byteen  output  4  byte lanes written
- m_wdata  output  32  lane-replicated store data
- m_ack  input  1  memory completes current request
- m_rdata  input  32  read word, valid with m_ack

## Operation
- States: IDLE, BUSY, DONE. Reset -> IDLE; all outputs 0.
- IDLE: req_valid=1 -> capture we/width/sign/addr/wdata, go BUSY, clear timeout counter.
- BUSY: m_req=1, bus outputs from captured registers, stable until ack. m_ack=1 -> DONE; load: rdata<=extended m_rdata, rdata_valid pulses in DONE. Counter reaches TIMEOUT without ack -> DONE, bus_err pulses, rdata<=0.
- DONE: stall=0; pipeline advances on this edge; req_valid ignored; -> IDLE next cycle.
- stall = (IDLE & req_valid) | BUSY.
- Byte enables: WORD 4'b1111; HALF addr[1] ? 4'b1100 : 4'b0011; BYTE 4'b0001 << addr[1:0]. Loads drive m_byteen=4'b1111.
- Store data: WORD as-is; HALF {2{wdata[15:0]}}; BYTE {4{wdata[7:0]}}.
- Load extract: HALF lane addr[1] (0 -> [15:0], 1 -> [31:16]); BYTE lane addr[1:0]; extend bit 15/7 if sign else zero.
- m_ack outside BUSY ignored.

## Timing
- Request at edge N (IDLE) -> m_req high from N+1. Ack sampled at edge K -> rdata_valid/stall=0 during cycle K+1, IDLE at K+2. Min latency: 2 cycles stalled + 1 DONE cycle.
- Ack in first BUSY cycle allowed (zero-wait memory).
- Timeout: abort on the edge where counter==TIMEOUT-1 without ack; m_req drops next cycle.
- Reset mid-access: immediate IDLE, m_req=0, counter cleared, no pulse outputs; memory side must discard partial request.
- Store data never changes while m_req=1.

## Configuration
- MEM_CTRL_ADDR_EXC_EN defined: adds outputs exc (1) and exc_code (5). In IDLE, misaligned request (WORD addr[1:0]!=0, HALF addr[0]=1) issues no bus cycle, goes straight to DONE, pulses exc with exc_code 5'd4 (load) or 5'd5 (store); rdata=0, no rdata_valid.
- Undefined: no exc ports; low address bits beyond lane selection ignored (WORD uses addr[31:2], HALF uses addr[1]).

## Test plan
- Word store addr 0x0000_0010, wdata 0x1234_5678, ack 1st BUSY cycle -> m_addr 0x10, m_byteen 4'b1111, m_wdata 0x12345678, stall 2 cycles.
- Byte store addr 0x13, wdata 0xAB -> m_byteen 4'b1000, m_wdata 0xABABABAB, m_addr 0x10.
- Load half signed addr 0x22, m_rdata 0x8001_0000 after 3 wait cycles -> rdata 0xFFFF_8001, rdata_valid 1 cycle, stall 5 cycles; unsigned -> 0x0000_8001.
- Load byte unsigned addr 0x41, m_rdata 0x0000_F700 -> rdata 0x0000_00F7.
- No ack, TIMEOUT=4 -> m_req high 4 cycles, bus_err pulse, rdata 0, back to IDLE.
- With MEM_CTRL_ADDR_EXC_EN: load word addr 0x06 -> m_req never asserted, exc=1, exc_code 4; reset asserted in BUSY -> m_req 0 asynchronously.

Source files
------------

// File: rtl/m_mem_ctrl_if.sv
// Word-organised data memory bus between the load/store initiator (master) and memory (slave).
interface m_mem_ctrl_if;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_byteen;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    modport master (
        output m_req, m_we, m_addr, m_byteen, m_wdata,
        input  m_ack, m_rdata
    );

    modport slave (
        input  m_req, m_we, m_addr, m_byteen, m_wdata,
        output m_ack, m_rdata
    );
endinterface

// File: rtl/m_mem_ctrl.sv
// Memory-stage load/store initiator with lane steering, load extension and ack timeout.
// MEM_CTRL_ADDR_EXC_EN adds misaligned-address exceptions (exc/exc_code) instead of a bus cycle.
module m_mem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_width,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        bus_err,
`ifdef MEM_CTRL_ADDR_EXC_EN
    output logic        exc,
    output logic [4:0]  exc_code,
`endif
    m_mem_ctrl_if.master bus
);

    // state | meaning
    // IDLE  | waiting for an M-stage access
    // BUSY  | bus request open, waiting for ack or timeout
    // DONE  | result/abort pulses visible, pipeline advances
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic        capture, load_done, abort;
    logic        cap_we, cap_sign;
    logic [1:0]  cap_width;
    logic [31:0] cap_addr, cap_wdata;
    logic [7:0]  cnt;
    logic [15:0] lane_h;
    logic [7:0]  lane_b;
    logic [31:0] load_ext;
    logic [3:0]  byteen;
    logic [31:0] wdata_rep;
    logic        busy;
`ifdef MEM_CTRL_ADDR_EXC_EN
    logic        exc_hit;
    logic        misaligned;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        capture   = 1'b0;
        load_done = 1'b0;
        abort     = 1'b0;
        stall     = 1'b0;
`ifdef MEM_CTRL_ADDR_EXC_EN
        exc_hit    = 1'b0;
        misaligned = (req_width == 2'b01) ? req_addr[0] :
                     (req_width == 2'b10) ? 1'b0 : (req_addr[1:0] != 2'b00);
`endif
        case (state)
            IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    capture  = 1'b1;
                    state_nx = BUSY;
`ifdef MEM_CTRL_ADDR_EXC_EN
                    if (misaligned) begin
                        exc_hit  = 1'b1;
                        state_nx = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (bus.m_ack) begin
                    state_nx  = DONE;
                    load_done = ~cap_we;
                end else if (cnt == CNT_LAST) begin
                    state_nx = DONE;
                    abort    = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_we      <= 1'b0;
            cap_sign    <= 1'b0;
            cap_width   <= 2'b00;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            cnt         <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
`ifdef MEM_CTRL_ADDR_EXC_EN
            exc         <= 1'b0;
            exc_code    <= '0;
`endif
        end else begin
            rdata_valid <= load_done;
            bus_err     <= abort;
            if (capture) begin
                cap_we    <= req_we;
                cap_sign  <= req_sign;
                cap_width <= req_width;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cnt       <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + 8'd1;
            end
            if (load_done)  rdata <= load_ext;
            else if (abort) rdata <= '0;
`ifdef MEM_CTRL_ADDR_EXC_EN
            exc      <= exc_hit;
            exc_code <= req_we ? 5'd5 : 5'd4;
            if (exc_hit) rdata <= '0;
`endif
        end
    end

    // Load lane selection and extension from the returned word
    always_comb begin
        lane_h = cap_addr[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
        case (cap_addr[1:0])
            2'd0:    lane_b = bus.m_rdata[7:0];
            2'd1:    lane_b = bus.m_rdata[15:8];
            2'd2:    lane_b = bus.m_rdata[23:16];
            default: lane_b = bus.m_rdata[31:24];
        endcase
        case (cap_width)
            2'b01:   load_ext = {{16{cap_sign & lane_h[15]}}, lane_h};
            2'b10:   load_ext = {{24{cap_sign & lane_b[7]}}, lane_b};
            default: load_ext = bus.m_rdata;
        endcase
    end

    // Store lane steering; loads always read the full word
    always_comb begin
        case (cap_width)
            2'b01: begin
                byteen    = cap_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{cap_wdata[15:0]}};
            end
            2'b10: begin
                byteen    = 4'b0001 << cap_addr[1:0];
                wdata_rep = {4{cap_wdata[7:0]}};
            end
            default: begin
                byteen    = 4'b1111;
                wdata_rep = cap_wdata;
            end
        endcase
        if (!cap_we) byteen = 4'b1111;
    end

    assign busy         = (state == BUSY);
    assign bus.m_req    = busy;
    assign bus.m_we     = busy & cap_we;
    assign bus.m_addr   = busy ? {cap_addr[31:2], 2'b00} : 32'h0;
    assign bus.m_byteen = busy ? byteen : 4'b0000;
    assign bus.m_wdata  = busy ? wdata_rep : 32'h0;

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Directed bench for m_mem_ctrl: timeline model per access plus literal expectations.
module tb_m_mem_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0;
    logic [1:0]  req_width = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        stall, rdata_valid, bus_err;
    logic [31:0] rdata;
`ifdef MEM_CTRL_ADDR_EXC_EN
    logic        exc;
    logic [4:0]  exc_code;
`endif

    m_mem_ctrl_if bus ();

    always #5 clk = ~clk;

    m_mem_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_width(req_width),
        .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .bus_err(bus_err),
`ifdef MEM_CTRL_ADDR_EXC_EN
        .exc(exc), .exc_code(exc_code),
`endif
        .bus(bus)
    );

    logic        exp_stall = 0, exp_req = 0, exp_rv = 0, exp_err = 0, exp_rd_chk = 0;
    logic        exp_we = 0, exp_exc = 0, lit_done = 0;
    logic [4:0]  exp_code = '0;
    logic [31:0] exp_addr = '0, exp_wd = '0, exp_rdata = '0, lit_rd = '0, lit_wd = '0;
    logic [3:0]  exp_be = '0, lit_be = '0;
    int          lit_stall = 0, lit_req = 0, stall_cnt = 0, req_cnt = 0;
    int          n_checks = 0, n_fail = 0;

    function automatic int size_of(input logic [1:0] w);
        return (w == 2'b01) ? 2 : (w == 2'b10) ? 1 : 4;
    endfunction

    function automatic int lane_off(input logic [1:0] w, input logic [31:0] a);
        int sz = size_of(w);
        return (int'(a[1:0]) / sz) * sz;
    endfunction

    function automatic logic [3:0] model_be(input logic we, input logic [1:0] w, input logic [31:0] a);
        int sz = size_of(w);
        if (!we) return 4'hF;
        return 4'(((1 << sz) - 1) << lane_off(w, a));
    endfunction

    function automatic logic [31:0] model_wd(input logic [1:0] w, input logic [31:0] d);
        logic [31:0] r;
        int sz = size_of(w);
        for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_ld(input logic [1:0] w, input logic s,
                                             input logic [31:0] a, input logic [31:0] word);
        int          sz = size_of(w);
        logic [63:0] m64 = (64'd1 << (8*sz)) - 64'd1;
        logic [31:0] mask = m64[31:0];
        logic [31:0] v = (word >> (8*lane_off(w, a))) & mask;
        if (s && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("m_req", 32'(bus.m_req), 32'(exp_req));
        chk("rdata_valid", 32'(rdata_valid), 32'(exp_rv));
        chk("bus_err", 32'(bus_err), 32'(exp_err));
        if (reset) chk("rst_rdata", rdata, 32'h0);
        if (exp_req) begin
            chk("m_we", 32'(bus.m_we), 32'(exp_we));
            chk("m_addr", bus.m_addr, exp_addr);
            chk("m_byteen", 32'(bus.m_byteen), 32'(exp_be));
            chk("m_byteen_lit", 32'(bus.m_byteen), 32'(lit_be));
            if (exp_we) begin
                chk("m_wdata", bus.m_wdata, exp_wd);
                chk("m_wdata_lit", bus.m_wdata, lit_wd);
            end
        end
        if (exp_rd_chk) begin
            chk("rdata", rdata, exp_rdata);
            chk("rdata_lit", rdata, lit_rd);
        end
`ifdef MEM_CTRL_ADDR_EXC_EN
        chk("exc", 32'(exc), 32'(exp_exc));
        if (exp_exc) chk("exc_code", 32'(exc_code), 32'(exp_code));
`endif
        if (reset) begin
            stall_cnt = 0;
            req_cnt   = 0;
        end else if (lit_done) begin
            chk("stall_cycles", 32'(stall_cnt), 32'(lit_stall));
            chk("m_req_cycles", 32'(req_cnt), 32'(lit_req));
            stall_cnt = 0;
            req_cnt   = 0;
        end else begin
            stall_cnt += int'(stall);
            req_cnt   += int'(bus.m_req);
        end
    end

    task automatic set_req(input logic we, input logic [1:0] w, input logic s,
                           input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_we = we; req_width = w; req_sign = s;
        req_addr = a; req_wdata = d;
        exp_stall = 1'b1; exp_req = 1'b0; exp_rv = 1'b0; exp_err = 1'b0; exp_rd_chk = 1'b0;
        exp_we = we; exp_addr = {a[31:2], 2'b00};
        exp_be = model_be(we, w, a); exp_wd = model_wd(w, d);
    endtask

    task automatic go_idle();
        req_valid = 1'b0; lit_done = 1'b0; exp_exc = 1'b0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_rv = 1'b0; exp_err = 1'b0; exp_rd_chk = 1'b0;
    endtask

    // waits < 0: memory never acks
    task automatic access(input logic we, input logic [1:0] w, input logic s,
                          input logic [31:0] a, input logic [31:0] d, input int waits,
                          input logic [31:0] word, input logic [31:0] l_rd, input logic [3:0] l_be,
                          input logic [31:0] l_wd, input int l_stall, input int l_req);
        int nb = (waits < 0) ? TO : waits + 1;
        set_req(we, w, s, a, d);
        lit_rd = l_rd; lit_be = l_be; lit_wd = l_wd; lit_stall = l_stall; lit_req = l_req;
        @(posedge clk); #1;
        for (int i = 0; i < nb; i++) begin
            exp_req = 1'b1;
            bus.m_ack   = (waits >= 0) && (i == waits);
            bus.m_rdata = bus.m_ack ? word : 32'hDEAD_BEEF;
            @(posedge clk); #1;
        end
        bus.m_ack = 1'b0; bus.m_rdata = 32'hDEAD_BEEF;
        exp_req = 1'b0; exp_stall = 1'b0;
        exp_rv = !we && (waits >= 0);
        exp_err = (waits < 0);
        exp_rd_chk = exp_rv || exp_err;
        exp_rdata = exp_err ? 32'h0 : model_ld(w, s, a, word);
        lit_done = 1'b1;
        @(posedge clk); #1;
        go_idle();
        bus.m_ack = 1'b1;
        @(posedge clk); #1;
        bus.m_ack = 1'b0;
    endtask

    task automatic reset_mid();
        set_req(1'b1, 2'b00, 1'b0, 32'h20, 32'h55AA_55AA);
        lit_be = 4'hF; lit_wd = 32'h55AA_55AA;
        @(posedge clk); #1;
        exp_req = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        go_idle();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

`ifdef MEM_CTRL_ADDR_EXC_EN
    task automatic exc_access(input logic we, input logic [1:0] w, input logic [31:0] a);
        set_req(we, w, 1'b0, a, 32'h0);
        lit_stall = 1; lit_req = 0; lit_rd = 32'h0;
        @(posedge clk); #1;
        exp_stall = 1'b0; exp_exc = 1'b1; exp_code = we ? 5'd5 : 5'd4;
        exp_rd_chk = 1'b1; exp_rdata = 32'h0; lit_done = 1'b1;
        @(posedge clk); #1;
        go_idle();
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        bus.m_ack = 1'b0;
        bus.m_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        access(1'b1, 2'b00, 1'b0, 32'h10, 32'h1234_5678, 0, 32'h0, 32'h0, 4'hF, 32'h1234_5678, 2, 1);
        access(1'b1, 2'b10, 1'b0, 32'h13, 32'h1234_56AB, 1, 32'h0, 32'h0, 4'h8, 32'hABAB_ABAB, 3, 2);
        access(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 3, 32'h8001_0000, 32'hFFFF_8001, 4'hF, 32'h0, 5, 4);
        access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 3, 32'h8001_0000, 32'h0000_8001, 4'hF, 32'h0, 5, 4);
        access(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 0, 32'h0000_F700, 32'h0000_00F7, 4'hF, 32'h0, 2, 1);
        access(1'b1, 2'b01, 1'b0, 32'h02, 32'h1234_CAFE, 0, 32'h0, 32'h0, 4'hC, 32'hCAFE_CAFE, 2, 1);
        access(1'b0, 2'b10, 1'b1, 32'h43, 32'h0, 2, 32'h8000_0000, 32'hFFFF_FF80, 4'hF, 32'h0, 4, 3);
`ifdef MEM_CTRL_ADDR_EXC_EN
        exc_access(1'b0, 2'b00, 32'h06);
        exc_access(1'b1, 2'b01, 32'h11);
`else
        access(1'b0, 2'b00, 1'b0, 32'h06, 32'h0, 0, 32'h89AB_CDEF, 32'h89AB_CDEF, 4'hF, 32'h0, 2, 1);
        access(1'b0, 2'b11, 1'b0, 32'h0B, 32'h0, 1, 32'h1357_2468, 32'h1357_2468, 4'hF, 32'h0, 3, 2);
`endif
        reset_mid();
        access(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, -1, 32'h0, 32'h0, 4'hF, 32'h0, 5, 4);
        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
